instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 24 ++
 rtl/instr_fetch.sv | 101 ++++++++++
 tb/tb_instr_fetch.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: sequencing controls, program-load port and the fetched
// instruction stream toward the control pipeline.
interface instr_fetch_if;
  logic       start;
  logic       stall;
  logic       prog_we;
  logic [5:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] instr;
  logic       instr_valid;
  logic [5:0] pc;
  logic       busy;
  logic       halted;

  modport master (
    output start, stall, prog_we, prog_addr, prog_data,
    input  instr, instr_valid, pc, busy, halted
  );

  modport slave (
    input  start, stall, prog_we, prog_addr, prog_data,
    output instr, instr_valid, pc, busy, halted
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: 64x8 program memory, branch squash and HALT.
//   state  | meaning
//   IDLE   | waiting for start, memory writable
//   FETCH  | presenting mem[fetch_pc] each unstalled cycle
//   SQUASH | one bubble after a taken branch
//   HALT   | 8'hFF fetched, memory writable, start restarts
module instr_fetch #(
  parameter int MEM_DEPTH = 64
) (
  input logic         clk,
  input logic         reset,
  instr_fetch_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_SQUASH = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  logic [7:0] mem_q [MEM_DEPTH];

  logic [1:0] state_q, state_d;
  logic [5:0] fetch_pc_q, fetch_pc_d;
  logic [5:0] pc_q, pc_d;
  logic [7:0] instr_q, instr_d;
  logic       valid_q, valid_d;
  logic [7:0] fetch_word;
  logic       mem_we;

  // Program memory is only writable while the fetcher is parked.
  assign mem_we = bus.prog_we && ((state_q == S_IDLE) || (state_q == S_HALT));

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[bus.prog_addr] <= bus.prog_data;
  end

  always_comb begin
    fetch_word = mem_q[fetch_pc_q];
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        instr_d = 8'h00;
        valid_d = 1'b0;
        if (bus.start) begin
          state_d    = S_FETCH;
          fetch_pc_d = 6'd0;
        end
      end
      S_FETCH: begin
        if (!bus.stall) begin
          instr_d    = fetch_word;
          pc_d       = fetch_pc_q;
          valid_d    = 1'b1;
          fetch_pc_d = fetch_pc_q + 6'd1;
          // 8'hFF has bit 7 set but is HALT, so it must be tested first.
          if (fetch_word == 8'hFF) begin
            state_d = S_HALT;
          end else if (fetch_word[7]) begin
            fetch_pc_d = fetch_word[5:0];
            state_d    = S_SQUASH;
          end
        end
      end
      S_SQUASH: begin
        if (!bus.stall) begin
          instr_d = 8'h00;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= 6'd0;
      pc_q       <= 6'd0;
      instr_q    <= 8'h00;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.busy        = (state_q == S_FETCH) || (state_q == S_SQUASH);
  assign bus.halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table for sequential fetch/stall,
// hand sequences for lockout, async reset, branch, wrap and self-loop.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  instr_fetch_if bus ();

  instr_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       sl;
    logic [7:0] ei;
    logic       ev;
    logic [5:0] ep;
    logic       eb;
    logic       eh;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] ei, input logic ev,
                         input logic [5:0] ep, input logic eb, input logic eh);
    chk({tag, "/instr"},  bus.instr, ei);
    chk({tag, "/valid"},  {7'd0, bus.instr_valid}, {7'd0, ev});
    chk({tag, "/pc"},     {2'd0, bus.pc}, {2'd0, ep});
    chk({tag, "/busy"},   {7'd0, bus.busy}, {7'd0, eb});
    chk({tag, "/halted"}, {7'd0, bus.halted}, {7'd0, eh});
  endtask

  task automatic step(input logic st, input logic sl, input logic [7:0] ei, input logic ev,
                      input logic [5:0] ep, input logic eb, input logic eh, input string tag);
    @(negedge clk);
    bus.start = st;
    bus.stall = sl;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk_out(tag, ei, ev, ep, eb, eh);
  endtask

  task automatic load(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    @(posedge clk);
    #1;
    bus.prog_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              st  sl  instr  v  pc  busy halt
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 6'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 8'h01, 1'b1, 6'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h02, 1'b1, 6'd1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'h02, 1'b1, 6'd1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'h02, 1'b1, 6'd1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'h02, 1'b1, 6'd1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 8'h03, 1'b1, 6'd2, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'hFF, 1'b1, 6'd3, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 6'd3, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 6'd3, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 6'd3, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h01, 1'b1, 6'd0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'h02, 1'b1, 6'd1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 8'h03, 1'b1, 6'd2, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 8'hFF, 1'b1, 6'd3, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 6'd3, 1'b0, 1'b1};

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.stall     = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = 6'd0;
    bus.prog_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_out("reset_hold", 8'h00, 1'b0, 6'd0, 1'b0, 1'b0);
    reset = 1'b0;

    load(6'd0, 8'h01);
    load(6'd1, 8'h02);
    load(6'd2, 8'h03);
    load(6'd3, 8'hFF);

    for (int i = 0; i < 16; i++)
      step(tbl[i].st, tbl[i].sl, tbl[i].ei, tbl[i].ev, tbl[i].ep, tbl[i].eb, tbl[i].eh,
           $sformatf("seq%0d", i));

    // Write to addr 2 while fetching must be dropped.
    step(1'b1, 1'b0, 8'h00, 1'b0, 6'd3, 1'b1, 1'b0, "lock_start");
    bus.prog_we   = 1'b1;
    bus.prog_addr = 6'd2;
    bus.prog_data = 8'h77;
    step(1'b0, 1'b0, 8'h01, 1'b1, 6'd0, 1'b1, 1'b0, "lock_w0");
    bus.prog_we = 1'b0;
    step(1'b0, 1'b0, 8'h02, 1'b1, 6'd1, 1'b1, 1'b0, "lock_w1");
    step(1'b0, 1'b0, 8'h03, 1'b1, 6'd2, 1'b1, 1'b0, "lock_w2");
    step(1'b0, 1'b0, 8'hFF, 1'b1, 6'd3, 1'b0, 1'b1, "lock_w3");
    step(1'b0, 1'b0, 8'h00, 1'b0, 6'd3, 1'b0, 1'b1, "lock_h");

    // Asynchronous reset in FETCH, checked between clock edges.
    step(1'b1, 1'b0, 8'h00, 1'b0, 6'd3, 1'b1, 1'b0, "rst_start");
    step(1'b0, 1'b0, 8'h01, 1'b1, 6'd0, 1'b1, 1'b0, "rst_w0");
    step(1'b0, 1'b0, 8'h02, 1'b1, 6'd1, 1'b1, 1'b0, "rst_w1");
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk_out("rst_async", 8'h00, 1'b0, 6'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 8'h00, 1'b0, 6'd0, 1'b1, 1'b0, "rerun_start");
    step(1'b0, 1'b0, 8'h01, 1'b1, 6'd0, 1'b1, 1'b0, "rerun_w0");
    step(1'b0, 1'b0, 8'h02, 1'b1, 6'd1, 1'b1, 1'b0, "rerun_w1");
    step(1'b0, 1'b0, 8'h03, 1'b1, 6'd2, 1'b1, 1'b0, "rerun_w2");
    step(1'b0, 1'b0, 8'hFF, 1'b1, 6'd3, 1'b0, 1'b1, "rerun_w3");
    step(1'b0, 1'b0, 8'h00, 1'b0, 6'd3, 1'b0, 1'b1, "rerun_h");

    // Branch 1 -> 5 with a stall held during the squash bubble.
    load(6'd1, 8'h85);
    load(6'd5, 8'h42);
    load(6'd6, 8'hFF);
    step(1'b1, 1'b0, 8'h00, 1'b0, 6'd3, 1'b1, 1'b0, "br_start");
    step(1'b0, 1'b0, 8'h01, 1'b1, 6'd0, 1'b1, 1'b0, "br_w0");
    step(1'b0, 1'b0, 8'h85, 1'b1, 6'd1, 1'b1, 1'b0, "br_w1");
    step(1'b0, 1'b1, 8'h85, 1'b1, 6'd1, 1'b1, 1'b0, "br_sqstall");
    step(1'b0, 1'b0, 8'h00, 1'b0, 6'd1, 1'b1, 1'b0, "br_bubble");
    step(1'b0, 1'b0, 8'h42, 1'b1, 6'd5, 1'b1, 1'b0, "br_w5");
    step(1'b0, 1'b0, 8'hFF, 1'b1, 6'd6, 1'b0, 1'b1, "br_w6");
    step(1'b0, 1'b0, 8'h00, 1'b0, 6'd6, 1'b0, 1'b1, "br_h");

    // Branch to 63, then sequential wrap 63 -> 0.
    load(6'd0, 8'hBF);
    load(6'd63, 8'h10);
    step(1'b1, 1'b0, 8'h00, 1'b0, 6'd6, 1'b1, 1'b0, "wr_start");
    step(1'b0, 1'b0, 8'hBF, 1'b1, 6'd0, 1'b1, 1'b0, "wr_w0");
    step(1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 1'b1, 1'b0, "wr_bubble");
    step(1'b0, 1'b0, 8'h10, 1'b1, 6'd63, 1'b1, 1'b0, "wr_w63");
    step(1'b0, 1'b0, 8'hBF, 1'b1, 6'd0, 1'b1, 1'b0, "wr_wrap");
    step(1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 1'b1, 1'b0, "wr_bubble2");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Start coinciding with a write of a self-branch at address 0.
    bus.prog_we   = 1'b1;
    bus.prog_addr = 6'd0;
    bus.prog_data = 8'h80;
    step(1'b1, 1'b0, 8'h00, 1'b0, 6'd0, 1'b1, 1'b0, "co_start");
    bus.prog_we = 1'b0;
    step(1'b0, 1'b0, 8'h80, 1'b1, 6'd0, 1'b1, 1'b0, "loop_w0");
    step(1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 1'b1, 1'b0, "loop_b0");
    step(1'b0, 1'b0, 8'h80, 1'b1, 6'd0, 1'b1, 1'b0, "loop_w1");
    step(1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 1'b1, 1'b0, "loop_b1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
